estagio_busca: RTL and testbench
================================

Name: estagio_busca

Overview:
Instruction-fetch stage of the RV32I core, directly upstream of the instruction ROM. Holds the program counter and drives the ROM byte address. Captures the returned 32-bit word into an IF/ID pipeline register, together with PC, PC+4 and a valid bit. Supports stall (hold) and redirect (branch/jump target from EX) with flush of the in-flight slot.

Parameters:
PC_INICIAL, 32'h00000000, PC value loaded on reset.
NOP, 32'h00000013, word written into instrucao_id on reset and on flush (ADDI x0,x0,0).

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
parar  input  1  stall request from hazard unit; holds PC and IF/ID
desvio_valido  input  1  redirect request (taken branch / JAL / JALR)
desvio_alvo  input  32  redirect byte address
barramento_endereco  output  32  byte address to instruction ROM (= pc)
barramento_instrucao  input  32  word returned combinationally by ROM for barramento_endereco
instrucao_id  output  32  IF/ID instruction register
pc_id  output  32  PC of instrucao_id
pc_mais4_id  output  32  pc_id + 4 (link value for JAL/JALR)
valido_id  output  1  IF/ID slot holds a real instruction
contador_busca  output  32  number of instructions accepted into IF/ID
erro_desalinhado  output  1  misaligned-target flag (see Optional Feature; 0 when compiled out)

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect): pc=PC_INICIAL, instrucao_id=NOP, pc_id=0, pc_mais4_id=0, valido_id=0, contador_busca=0, erro_desalinhado=0. Effect is immediate, not on the next edge.
- barramento_endereco = pc, combinationally. The ROM is combinational, so the fetch-to-IF/ID latency is 1 cycle.
- Per rising edge, out of reset, the following cases apply in priority order:
  1. desvio_valido=1 (wins over parar): pc <= {desvio_alvo[31:2],2'b00}. IF/ID is flushed: instrucao_id <= NOP, valido_id <= 0. pc_id and pc_mais4_id hold. Counter holds.
  2. parar=1: pc, IF/ID and counter all hold.
  3. Otherwise: instrucao_id <= barramento_instrucao, pc_id <= pc, pc_mais4_id <= pc+4, valido_id <= 1, pc <= pc+4, contador_busca <= contador_busca+1.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000. contador_busca also wraps modulo 2^32.
- pc[1:0] is always 00.
- There is no FSM beyond these three update cases. The first instruction reaches IF/ID on the first edge after reset deasserts.

Optional Feature:
Macro BUSCA_ALINHAMENTO_EN.
- Defined: on an edge where desvio_valido=1 and desvio_alvo[1:0]!=00, erro_desalinhado <= 1 for exactly one cycle. On every other edge it is <= 0. The redirect is still performed with the low bits cleared.
- Undefined: erro_desalinhado is tied to 0 and no check logic is present.

Test Plan:
- Reset then release, ROM loaded with the standard test program -> barramento_endereco=0 during reset. Edge 1: instrucao_id=32'h00000093, pc_id=0, pc_mais4_id=4, valido_id=1. Edge 2: instrucao_id=32'h00A00113, pc_id=4. contador_busca=2.
- parar=1 for 3 cycles after pc reaches 8 -> barramento_endereco stays 8, instrucao_id stays 32'h00A00113, counter frozen. After release, next edge: instrucao_id=32'h0020A023, pc_id=8.
- desvio_valido=1, desvio_alvo=32'h10 while pc=8, with parar=1 in the same cycle -> next cycle pc=32'h10, valido_id=0, instrucao_id=32'h00000013. Following edge: instrucao_id=32'h00310463, pc_id=32'h10, valido_id=1.
- Redirect to 32'hFFFFFFFC, then run 2 edges -> pc_id=32'hFFFFFFFC, pc_mais4_id=0, pc=0 then 4 (wrap-around).
- Assert reset asynchronously between edges while pc=32'h14 and valido_id=1 -> outputs take reset values before the next edge. barramento_endereco=0.
- With BUSCA_ALINHAMENTO_EN defined, redirect to 32'h0000001A -> pc=32'h18, erro_desalinhado=1 for one cycle then 0. Without the macro, erro_desalinhado stays 0.

Source files
------------

// File: rtl/estagio_busca_if.sv
// ----------------------------------------------------------------------------
// estagio_busca_if
// Instruction-ROM bus between the fetch stage and the ROM.
//   barramento_endereco  : byte address driven by the fetch stage (word aligned)
//   barramento_instrucao : 32-bit word returned combinationally by the ROM
// Modports:
//   master : fetch stage (drives the address, reads the word)
//   slave  : ROM (reads the address, drives the word)
// ----------------------------------------------------------------------------
interface estagio_busca_if;
    logic [31:0] barramento_endereco;
    logic [31:0] barramento_instrucao;

    modport master (
        output barramento_endereco,
        input  barramento_instrucao
    );

    modport slave (
        input  barramento_endereco,
        output barramento_instrucao
    );
endinterface

// File: rtl/estagio_busca.sv
// ----------------------------------------------------------------------------
// estagio_busca
// RV32I instruction-fetch stage. Holds the PC, addresses the combinational
// instruction ROM and registers the returned word into the IF/ID register
// together with its PC, PC+4 and a valid bit. Supports stall and redirect
// (redirect flushes the IF/ID slot and takes priority over stall).
//
// Parameters:
//   PC_INICIAL : PC loaded on reset
//   NOP        : word placed in instrucao_id on reset and on flush
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   parar             : stall, holds PC, IF/ID and fetch counter
//   desvio_valido     : redirect request
//   desvio_alvo       : redirect byte address (low two bits ignored)
//   bus (master)      : ROM address out / instruction word in
//   instrucao_id      : IF/ID instruction
//   pc_id             : PC of instrucao_id
//   pc_mais4_id       : pc_id + 4 (link value)
//   valido_id         : IF/ID slot holds a real instruction
//   contador_busca    : instructions accepted into IF/ID (wraps)
//   erro_desalinhado  : one-cycle pulse on a redirect to a non-word-aligned
//                       target; only built when BUSCA_ALINHAMENTO_EN is
//                       defined, otherwise tied to 0
// ----------------------------------------------------------------------------
module estagio_busca #(
    parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   parar,
    input  logic                   desvio_valido,
    input  logic [31:0]            desvio_alvo,
    estagio_busca_if.master        bus,
    output logic [31:0]            instrucao_id,
    output logic [31:0]            pc_id,
    output logic [31:0]            pc_mais4_id,
    output logic                   valido_id,
    output logic [31:0]            contador_busca,
    output logic                   erro_desalinhado
);

    logic [31:0] pc;
    logic [31:0] pc_mais4;

    // Natural 32-bit overflow gives the required modulo-2^32 wrap.
    assign pc_mais4                = pc + 32'd4;
    assign bus.barramento_endereco = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= {PC_INICIAL[31:2], 2'b00};
            instrucao_id   <= NOP;
            pc_id          <= 32'h0000_0000;
            pc_mais4_id    <= 32'h0000_0000;
            valido_id      <= 1'b0;
            contador_busca <= 32'h0000_0000;
        end else if (desvio_valido) begin
            // Redirect wins over stall; pc_id/pc_mais4_id and the counter hold.
            pc           <= {desvio_alvo[31:2], 2'b00};
            instrucao_id <= NOP;
            valido_id    <= 1'b0;
        end else if (!parar) begin
            instrucao_id   <= bus.barramento_instrucao;
            pc_id          <= pc;
            pc_mais4_id    <= pc_mais4;
            valido_id      <= 1'b1;
            pc             <= pc_mais4;
            contador_busca <= contador_busca + 32'd1;
        end
    end

`ifdef BUSCA_ALINHAMENTO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            erro_desalinhado <= 1'b0;
        end else begin
            erro_desalinhado <= desvio_valido && (desvio_alvo[1:0] != 2'b00);
        end
    end
`else
    assign erro_desalinhado = 1'b0;
`endif

endmodule

// File: tb/tb_estagio_busca.sv
// ----------------------------------------------------------------------------
// tb_estagio_busca
// Directed bench for estagio_busca with a small combinational ROM holding the
// standard test program. Outputs are sampled 1 time unit after each rising
// edge; inputs are changed at the same point.
// ----------------------------------------------------------------------------
module tb_estagio_busca;

    logic        clk;
    logic        reset;
    logic        parar;
    logic        desvio_valido;
    logic [31:0] desvio_alvo;
    logic [31:0] instrucao_id;
    logic [31:0] pc_id;
    logic [31:0] pc_mais4_id;
    logic        valido_id;
    logic [31:0] contador_busca;
    logic        erro_desalinhado;

    int n_vetores;
    int n_erros;

`ifdef BUSCA_ALINHAMENTO_EN
    localparam logic ERRO_ESPERADO = 1'b1;
`else
    localparam logic ERRO_ESPERADO = 1'b0;
`endif

    estagio_busca_if bus ();

    estagio_busca dut (
        .clk              (clk),
        .reset            (reset),
        .parar            (parar),
        .desvio_valido    (desvio_valido),
        .desvio_alvo      (desvio_alvo),
        .bus              (bus),
        .instrucao_id     (instrucao_id),
        .pc_id            (pc_id),
        .pc_mais4_id      (pc_mais4_id),
        .valido_id        (valido_id),
        .contador_busca   (contador_busca),
        .erro_desalinhado (erro_desalinhado)
    );

    // Standard test program; any other address returns a tagged filler word.
    always_comb begin
        case (bus.barramento_endereco)
            32'h0000_0000: bus.barramento_instrucao = 32'h0000_0093;
            32'h0000_0004: bus.barramento_instrucao = 32'h00A0_0113;
            32'h0000_0008: bus.barramento_instrucao = 32'h0020_A023;
            32'h0000_000C: bus.barramento_instrucao = 32'h0000_A183;
            32'h0000_0010: bus.barramento_instrucao = 32'h0031_0463;
            32'h0000_0014: bus.barramento_instrucao = 32'h0010_0213;
            32'h0000_0018: bus.barramento_instrucao = 32'h0040_0293;
            32'hFFFF_FFFC: bus.barramento_instrucao = 32'hDEAD_BEEF;
            default:       bus.barramento_instrucao = 32'h0BAD_0BAD;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vetores++;
        assert (obs === exp) else begin
            n_erros++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic borda;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vetores     = 0;
        n_erros       = 0;
        reset         = 1'b1;
        parar         = 1'b0;
        desvio_valido = 1'b0;
        desvio_alvo   = 32'h0;

        // Reset state
        #3;
        chk("rst_endereco", bus.barramento_endereco, 32'h0);
        chk("rst_instrucao", instrucao_id, 32'h0000_0013);
        chk("rst_valido", {31'b0, valido_id}, 32'h0);
        chk("rst_contador", contador_busca, 32'h0);
        chk("rst_erro", {31'b0, erro_desalinhado}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Edge 1 / edge 2 after reset
        borda();
        chk("e1_instrucao", instrucao_id, 32'h0000_0093);
        chk("e1_pc_id", pc_id, 32'h0);
        chk("e1_pc_mais4", pc_mais4_id, 32'h4);
        chk("e1_valido", {31'b0, valido_id}, 32'h1);
        borda();
        chk("e2_instrucao", instrucao_id, 32'h00A0_0113);
        chk("e2_pc_id", pc_id, 32'h4);
        chk("e2_contador", contador_busca, 32'h2);
        chk("e2_endereco", bus.barramento_endereco, 32'h8);

        // Stall for three cycles at pc=8
        parar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            borda();
            chk("stall_endereco", bus.barramento_endereco, 32'h8);
            chk("stall_instrucao", instrucao_id, 32'h00A0_0113);
            chk("stall_contador", contador_busca, 32'h2);
        end
        parar = 1'b0;
        borda();
        chk("rel_instrucao", instrucao_id, 32'h0020_A023);
        chk("rel_pc_id", pc_id, 32'h8);
        chk("rel_contador", contador_busca, 32'h3);

        // Redirect to 0x10 with a simultaneous stall (redirect wins)
        parar         = 1'b1;
        desvio_valido = 1'b1;
        desvio_alvo   = 32'h10;
        borda();
        chk("dsv_endereco", bus.barramento_endereco, 32'h10);
        chk("dsv_valido", {31'b0, valido_id}, 32'h0);
        chk("dsv_instrucao", instrucao_id, 32'h0000_0013);
        chk("dsv_pc_id_hold", pc_id, 32'h8);
        chk("dsv_contador_hold", contador_busca, 32'h3);
        chk("dsv_erro_alinhado", {31'b0, erro_desalinhado}, 32'h0);
        parar         = 1'b0;
        desvio_valido = 1'b0;
        borda();
        chk("pos_dsv_instrucao", instrucao_id, 32'h0031_0463);
        chk("pos_dsv_pc_id", pc_id, 32'h10);
        chk("pos_dsv_valido", {31'b0, valido_id}, 32'h1);
        chk("pos_dsv_contador", contador_busca, 32'h4);

        // Asynchronous reset between edges at pc=0x14
        chk("pre_rst_endereco", bus.barramento_endereco, 32'h14);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_endereco", bus.barramento_endereco, 32'h0);
        chk("arst_instrucao", instrucao_id, 32'h0000_0013);
        chk("arst_pc_id", pc_id, 32'h0);
        chk("arst_pc_mais4", pc_mais4_id, 32'h0);
        chk("arst_valido", {31'b0, valido_id}, 32'h0);
        chk("arst_contador", contador_busca, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Redirect to the top of the address space, then wrap
        desvio_valido = 1'b1;
        desvio_alvo   = 32'hFFFF_FFFC;
        borda();
        chk("top_endereco", bus.barramento_endereco, 32'hFFFF_FFFC);
        chk("top_contador", contador_busca, 32'h0);
        desvio_valido = 1'b0;
        borda();
        chk("wrap_pc_id", pc_id, 32'hFFFF_FFFC);
        chk("wrap_pc_mais4", pc_mais4_id, 32'h0);
        chk("wrap_instrucao", instrucao_id, 32'hDEAD_BEEF);
        chk("wrap_endereco", bus.barramento_endereco, 32'h0);
        borda();
        chk("wrap2_endereco", bus.barramento_endereco, 32'h4);
        chk("wrap2_pc_id", pc_id, 32'h0);
        chk("wrap2_contador", contador_busca, 32'h2);

        // Misaligned redirect target
        desvio_valido = 1'b1;
        desvio_alvo   = 32'h0000_001A;
        borda();
        chk("desal_endereco", bus.barramento_endereco, 32'h18);
        chk("desal_erro", {31'b0, erro_desalinhado}, {31'b0, ERRO_ESPERADO});
        chk("desal_contador", contador_busca, 32'h2);
        desvio_valido = 1'b0;
        borda();
        chk("desal_erro_fim", {31'b0, erro_desalinhado}, 32'h0);
        chk("desal_instrucao", instrucao_id, 32'h0040_0293);
        chk("desal_pc_id", pc_id, 32'h18);
        chk("desal_contador2", contador_busca, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
        $finish;
    end

endmodule
